arch_reg_dump_master: RTL and testbench
=======================================

Name: arch_reg_dump_master

Overview:
- Master-side requester for the architectural register read interface the CPU top exposes as a slave.
- On a start pulse, waits until the core is quiescent, then reads every architectural register in index order.
- Streams each (index, value) pair out on a valid/ready port for the testbench scoreboard or debug link.
- Sits outside the CPU, wired to its architectural-register read port.

Parameters:
- NUM_ARCH_REGS, 32, number of architectural registers walked (must be ≥2).
- DATA_W, 32, register value width.
- ADDR_W, $clog2(NUM_ARCH_REGS), register index width (derived; not overridden).
- READ_LATENCY, 1, cycles from rd_addr/rd_en to rd_data valid (1..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a dump; ignored unless state is IDLE
- quiesce  in  1  high when the ROB is empty and no commit is pending
- rd_en  out  1  read request toward the architectural register read interface
- rd_addr  out  ADDR_W  architectural register index being read
- rd_data  in  DATA_W  read data, valid READ_LATENCY cycles after rd_en
- out_valid  out  1  dump beat valid
- out_ready  in  1  consumer accepts beat
- out_index  out  ADDR_W  register index of beat
- out_data  out  DATA_W  register value of beat
- out_last  out  1  beat is register NUM_ARCH_REGS-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last beat handshakes

Behaviour:
- Reset: state=IDLE; index=0; rd_en=0, rd_addr=0, out_valid=0, out_index=0, out_data=0, out_last=0, busy=0, done=0; latency counter=0.
- FSM states: IDLE, WAIT_Q, ISSUE, WAIT_DATA, SEND, DONE.
- IDLE: start=1 -> WAIT_Q; index←0.
- WAIT_Q: stay while quiesce=0. When quiesce=1 -> ISSUE. Quiesce is sampled only here; a mid-dump deassert is ignored (bench owns consistency).
- ISSUE: rd_en=1 and rd_addr=index for exactly one cycle; latency counter←READ_LATENCY-1 -> WAIT_DATA.
- WAIT_DATA: decrement counter each cycle; at 0, capture rd_data into out_data, out_index←index, out_last←(index==NUM_ARCH_REGS-1) -> SEND.
- Timing: with READ_LATENCY=1, data is captured in the cycle after ISSUE; per-register cost is READ_LATENCY+2 cycles minimum.
- SEND: out_valid=1. out_data, out_index and out_last are held stable until out_valid&&out_ready; valid never drops without a handshake.
  - On handshake with out_last=0: index←index+1 -> ISSUE.
  - On handshake with out_last=1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start while busy: ignored, no queuing.
- reset in any state: immediate return to reset values; a partially streamed dump is abandoned with no out_last or done.
- Index never wraps within a dump; the last read index is NUM_ARCH_REGS-1.
- rd_en is never asserted outside ISSUE.
- Register x0 is read like any other; its value is passed through unmodified.

Optional Feature:
- Macro: ARCH_DUMP_CHECKSUM_EN
- Enabled:
  - Adds output checksum (DATA_W).
  - checksum is cleared when start is accepted.
  - On every SEND handshake: checksum←(checksum rotated left by 1) XOR out_data.
  - checksum is stable and valid while done=1 and holds its value until the next accepted start.
- Disabled: no checksum port and no checksum logic.

Decomposition:
- Shared package (cpu_pkg): ARCH_REG_NUM, ARCH_REG_ADDR_W, XLEN, and the enum dump_state_t (IDLE, WAIT_Q, ISSUE, WAIT_DATA, SEND, DONE).
- Sub-module: arch_dump_lat_cnt, a small down-counter with load and zero flag for READ_LATENCY.

Test Plan:
- Full dump, quiesce=1, out_ready=1, READ_LATENCY=1, reg[i]=i*0x11 -> 32 beats in index order 0..31; out_last only on index 31; done pulses once; rd_en asserted exactly 32 times.
- Backpressure: out_ready toggling 1/0 every cycle -> beat data/index held stable while out_valid=1 and out_ready=0; no beats lost or duplicated.
- Quiesce gating: start with quiesce=0 for 10 cycles, then 1 -> no rd_en during the 10 cycles; first rd_addr=0 on the cycle after entering ISSUE.
- start pulsed at beat 5 of a running dump -> ignored; dump completes with exactly 32 beats and a single done.
- Reset asserted during SEND of index 7 -> next cycle all outputs at reset values; a new start produces a clean 32-beat dump beginning at index 0.
- With ARCH_DUMP_CHECKSUM_EN and all registers = 0xFFFFFFFF -> checksum at done equals the bench model of rotl1-XOR over 32 words; READ_LATENCY=3 run yields identical beats.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the architectural register dump master:
// register-file geometry, data width and the dump FSM state encoding.
package cpu_pkg;

  localparam int ARCH_REG_NUM     = 32;
  localparam int ARCH_REG_ADDR_W  = $clog2(ARCH_REG_NUM);
  localparam int XLEN             = 32;

  // Read latency is bounded to 1..4, so the down-counter only ever holds 0..3.
  localparam int MAX_READ_LATENCY = 4;
  localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_Q    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DATA = 3'd3,
    SEND      = 3'd4,
    DONE      = 3'd5
  } dump_state_t;

endpackage

// File: rtl/arch_dump_lat_cnt.sv
// Read-latency down-counter: loads READ_LATENCY-1 when a read issues and
// raises zero in the cycle the read data is valid.
module arch_dump_lat_cnt
  import cpu_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/arch_reg_dump_master.sv
// Walks every architectural register once the core is quiescent and streams
// (index, value) beats on a valid/ready port. Optional rotl1-XOR checksum of
// the streamed values is enabled with ARCH_DUMP_CHECKSUM_EN.
module arch_reg_dump_master
  import cpu_pkg::*;
#(
  parameter  int NUM_ARCH_REGS = ARCH_REG_NUM,
  parameter  int DATA_W        = XLEN,
  parameter  int READ_LATENCY  = 1,
  localparam int ADDR_W        = $clog2(NUM_ARCH_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              quiesce,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
`ifdef ARCH_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output dump_state_t       dbg_state
);

  // Output handshake: a beat transfers on any rising edge where out_valid and
  // out_ready are both high; once out_valid rises, out_index/out_data/out_last
  // stay frozen and out_valid stays high until that transfer happens.

  localparam logic [ADDR_W-1:0]    LAST_INDEX = ADDR_W'(NUM_ARCH_REGS - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(READ_LATENCY - 1);

  if (NUM_ARCH_REGS < 2) begin : g_bad_regs
    $error("arch_reg_dump_master: NUM_ARCH_REGS must be at least 2");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_lat
    $error("arch_reg_dump_master: READ_LATENCY must be in 1..4");
  end

  dump_state_t       state_q;
  dump_state_t       state_d;
  logic [ADDR_W-1:0] index;
  logic              accept;
  logic              capture;
  logic              advance;
  logic              lat_load;
  logic              lat_dec;
  logic              lat_zero;
  logic              handshake;

  arch_dump_lat_cnt #(
    .W(LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    accept   = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = WAIT_Q;
        end
      end
      WAIT_Q: begin
        if (quiesce) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_en    = 1'b1;
        rd_addr  = index;
        lat_load = 1'b1;
        state_d  = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (lat_zero) begin
          capture = 1'b1;
          state_d = SEND;
        end else begin
          lat_dec = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      index     <= '0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        index <= '0;
      end else if (advance) begin
        index <= index + 1'b1;
      end
      if (capture) begin
        out_data  <= rd_data;
        out_index <= index;
        out_last  <= (index == LAST_INDEX);
      end
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign handshake = out_valid && out_ready;
  assign dbg_state = state_q;

`ifdef ARCH_DUMP_CHECKSUM_EN
  // Folded over beats as they are accepted, so it reflects exactly what the
  // consumer received; it is left untouched from DONE until the next start.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      checksum <= '0;
    end else if (handshake) begin
      checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ out_data;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_arch_reg_dump_master.sv
// Bench for arch_reg_dump_master: two instances (read latency 1 and 3) share
// stimulus; a register-file model and an expected-beat queue check both.
module tb_arch_reg_dump_master;
  import cpu_pkg::*;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, quiesce, out_ready;

  logic              rd_en     [2];
  logic [AW-1:0]     rd_addr   [2];
  logic [DW-1:0]     rd_data   [2];
  logic              out_valid [2];
  logic [AW-1:0]     out_index [2];
  logic [DW-1:0]     out_data  [2];
  logic              out_last  [2];
  logic              busy      [2];
  logic              done      [2];
  dump_state_t       dbg_state [2];
`ifdef ARCH_DUMP_CHECKSUM_EN
  logic [DW-1:0]     checksum  [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    arch_reg_dump_master #(
      .NUM_ARCH_REGS (N),
      .DATA_W        (DW),
      .READ_LATENCY  (LAT)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .quiesce   (quiesce),
      .rd_en     (rd_en[g]),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_index (out_index[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .busy      (busy[g]),
      .done      (done[g]),
`ifdef ARCH_DUMP_CHECKSUM_EN
      .checksum  (checksum[g]),
`endif
      .dbg_state (dbg_state[g])
    );
  end

  // ---------------- register file slave model ----------------
  logic [DW-1:0] mem  [N];
  logic [DW-1:0] pipe [2][3];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= rd_en[g] ? mem[rd_addr[g]] : JUNK;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end
  assign rd_data[0] = pipe[0][0];
  assign rd_data[1] = pipe[1][2];

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  dump_id = 0;
  logic [DW-1:0] pin31;
  logic chk_rst, chk_end, q_low, tmo;
`ifdef ARCH_DUMP_CHECKSUM_EN
  logic [DW-1:0] exp_cks;
  logic          pin_c = 1'b0;
  logic [DW-1:0] pin_cks = '0;
`endif

  int            seen_id  [2];
  int            rp       [2];
  int            rd_cnt   [2];
  int            done_cnt [2];
  logic          hold     [2];
  logic [AW-1:0] hold_idx [2];
  logic [DW-1:0] hold_dat [2];

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h (t=%0t)", name, g, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic [AW+DW-1:0] e;
      if (dump_id != seen_id[g]) begin
        seen_id[g]  = dump_id;
        rp[g]       = 0;
        rd_cnt[g]   = 0;
        done_cnt[g] = 0;
      end
      if (reset) begin
        hold[g] = 1'b0;
        if (chk_rst) begin
          chk("rst_rd_en", g, rd_en[g], 0);
          chk("rst_rd_addr", g, rd_addr[g], 0);
          chk("rst_out_valid", g, out_valid[g], 0);
          chk("rst_out_index", g, out_index[g], 0);
          chk("rst_out_data", g, out_data[g], 0);
          chk("rst_out_last", g, out_last[g], 0);
          chk("rst_busy", g, busy[g], 0);
          chk("rst_done", g, done[g], 0);
          chk("rst_state", g, dbg_state[g], IDLE);
        end
      end else begin
        if (q_low) chk("quiesce_wait", g, {busy[g], rd_en[g], out_valid[g]}, 3'b100);
        if (hold[g]) begin
          chk("hold_valid", g, out_valid[g], 1);
          chk("hold_index", g, out_index[g], hold_idx[g]);
          chk("hold_data", g, out_data[g], hold_dat[g]);
        end
        if (rd_en[g]) begin
          rd_cnt[g]++;
          chk("rd_en_ctx", g, {busy[g], out_valid[g], done[g]}, 3'b100);
          if (rp[g] < exp_q.size()) begin
            e = exp_q[rp[g]];
            chk("rd_addr", g, rd_addr[g], e[AW+DW-1:DW]);
          end else chk("rd_unexpected", g, 1, 0);
        end
        if (out_valid[g] && out_ready) begin
          if (rp[g] < exp_q.size()) begin
            e = exp_q[rp[g]];
            chk("beat_index", g, out_index[g], e[AW+DW-1:DW]);
            chk("beat_data", g, out_data[g], e[DW-1:0]);
            chk("beat_last", g, out_last[g], (rp[g] == N-1));
            if (rp[g] == N-1) chk("beat31_literal", g, out_data[g], pin31);
          end else chk("beat_unexpected", g, 1, 0);
          rp[g]++;
        end
        if (done[g]) begin
          done_cnt[g]++;
          chk("done_after_last", g, rp[g], N);
`ifdef ARCH_DUMP_CHECKSUM_EN
          chk("checksum", g, checksum[g], exp_cks);
          if (pin_c) chk("checksum_literal", g, checksum[g], pin_cks);
`endif
        end
        if (chk_end) begin
          chk("done_count", g, done_cnt[g], 1);
          chk("beat_count", g, rp[g], N);
          chk("rd_en_count", g, rd_cnt[g], N);
        end
        hold[g]     = out_valid[g] && !out_ready;
        hold_idx[g] = out_index[g];
        hold_dat[g] = out_data[g];
      end
    end
    if (tmo) chk("timeout", 0, 1, 0);
  end

  // ---------------- driver ----------------
  task automatic run_dump(input int rmode, input int q_delay, input int start_at,
                          input int rst_at, input logic [DW-1:0] p31);
    int c = 0;
    bit fin = 0;
    bit aborted = 0;
    bit injected = 0;
`ifdef ARCH_DUMP_CHECKSUM_EN
    logic [DW-1:0] cs = '0;
`endif
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({AW'(i), mem[i]});
`ifdef ARCH_DUMP_CHECKSUM_EN
      cs = {cs[DW-2:0], cs[DW-1]} ^ mem[i];
`endif
    end
`ifdef ARCH_DUMP_CHECKSUM_EN
    exp_cks = cs;
`endif
    pin31   = p31;
    dump_id = dump_id + 1;
    quiesce = (q_delay == 0);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (q_delay > 0) begin
      q_low = 1'b1;
      repeat (q_delay) begin @(posedge clk); #1; end
      q_low = 1'b0;
      quiesce = 1'b1;
    end
    while (!fin && c < 4000) begin
      start = 1'b0;
      if (start_at >= 0 && !injected && out_valid[0] && out_index[0] == AW'(start_at)) begin
        start = 1'b1;
        injected = 1;
      end
      if (rst_at >= 0 && out_valid[0] && out_index[0] == AW'(rst_at)) begin
        reset = 1'b1;
        fin = 1;
        aborted = 1;
      end
      out_ready = (rmode == 0) ? 1'b1 : c[0];
      if (!busy[0] && !busy[1]) fin = 1;
      if (!fin) begin @(posedge clk); #1; c++; end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!fin) begin
      tmo = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      tmo = 1'b0; reset = 1'b0;
    end else if (aborted) begin
      @(posedge clk); #1;
      chk_rst = 1'b1;
      @(posedge clk); #1;
      chk_rst = 1'b0;
      reset = 1'b0;
    end else begin
      chk_end = 1'b1;
      @(posedge clk); #1;
      chk_end = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; quiesce = 1'b1; out_ready = 1'b1;
    chk_rst = 1'b0; chk_end = 1'b0; q_low = 1'b0; tmo = 1'b0; pin31 = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    @(posedge clk); #1;
    chk_rst = 1'b1;
    @(posedge clk); #1;
    chk_rst = 1'b0;
    reset = 1'b0;

    // Full dump, reg[i] = i*0x11, no backpressure; reg31 = 0x20F.
    for (int i = 0; i < N; i++) mem[i] = DW'(i * 32'h11);
    run_dump(0, 0, -1, -1, 32'h0000_020F);

    // Backpressure: out_ready toggles every cycle.
    for (int i = 0; i < N; i++) mem[i] = DW'(i * 32'h11) ^ 32'h5A5A_0000;
    run_dump(1, 0, -1, -1, 32'h5A5A_020F);

    // Quiesce held low for 10 cycles; all-ones registers fold to checksum 0.
`ifdef ARCH_DUMP_CHECKSUM_EN
    pin_c = 1'b1; pin_cks = 32'h0000_0000;
`endif
    for (int i = 0; i < N; i++) mem[i] = 32'hFFFF_FFFF;
    run_dump(0, 10, -1, -1, 32'hFFFF_FFFF);

    // Start re-pulsed at beat 5; x0 passes through; checksum = rotr1(0xDEADBEEF).
`ifdef ARCH_DUMP_CHECKSUM_EN
    pin_cks = 32'hEF56_DF77;
`endif
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[0] = 32'hDEAD_BEEF;
    run_dump(0, 0, 5, -1, 32'h0000_0000);

    // Reset while beat 7 is on offer, then a clean dump from index 0.
`ifdef ARCH_DUMP_CHECKSUM_EN
    pin_c = 1'b0;
`endif
    for (int i = 0; i < N; i++) mem[i] = DW'(i * 32'h11);
    run_dump(1, 0, -1, 7, 32'h0000_020F);
    run_dump(0, 0, -1, -1, 32'h0000_020F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
